// File: rtl/anton_neopixel_stream.sv
// Streams a byte buffer out as a WS2812-style single-wire pulse train, MSB first,
// followed by a low latch period and a one-cycle end-of-frame pulse.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 8191
`endif

module anton_neopixel_stream #(
  parameter int unsigned BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int unsigned CYCLES_T0H   = 20,
  parameter int unsigned CYCLES_T1H   = 40,
  parameter int unsigned CYCLES_BIT   = 63,
  parameter int unsigned CYCLES_RESET = 2500
) (
  input  logic                              busClk,
  input  logic                              busRst,
  input  logic [12:0]                       regMax,
  input  logic                              regCtrlLimit,
  input  logic                              regCtrlRun,
  input  logic                              regCtrl32bit,
  output logic [$clog2(BUFFER_END+1)-1:0]   pixelAddr,
  input  logic [7:0]                        pixelData,
  output logic                              neoData,
  output logic                              streamSyncOf,
  output logic                              state
);

  localparam int unsigned AddrW  = $clog2(BUFFER_END + 1);
  localparam int unsigned CntMax = (CYCLES_BIT > CYCLES_RESET) ? CYCLES_BIT : CYCLES_RESET;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0] BitLast   = CntW'(CYCLES_BIT - 1);
  localparam logic [CntW-1:0] BitLoad   = CntW'(CYCLES_BIT - 2);
  localparam logic [CntW-1:0] LatchLast = CntW'(CYCLES_RESET - 1);
  localparam logic [CntW-1:0] T0hCnt    = CntW'(CYCLES_T0H);
  localparam logic [CntW-1:0] T1hCnt    = CntW'(CYCLES_T1H);

  typedef enum logic [1:0] {StIdle, StLoad, StBit, StLatch} fsmState_e;

  fsmState_e        fsmQ, fsmD;
  logic [AddrW-1:0] byteIdxQ, byteIdxD;
  logic [AddrW-1:0] lastIdxQ, lastIdxD;
  logic             mode32Q, mode32D;
  logic [7:0]       shiftQ, shiftD;
  logic [2:0]       bitCntQ, bitCntD;
  logic [CntW-1:0]  cntQ, cntD;

  logic [AddrW-1:0] lastSel;
  logic [AddrW:0]   idxInc, nextIdx;
  logic             isLast;

  always_comb begin
    lastSel = AddrW'(BUFFER_END);
    if (regCtrlLimit && (32'(regMax) < BUFFER_END)) begin
      lastSel = AddrW'(regMax);
    end
  end

  // Next byte to send, skipping the fourth byte of each word in 32-bit mode.
  always_comb begin
    idxInc  = {1'b0, byteIdxQ} + (AddrW+1)'(1);
    nextIdx = idxInc;
    if (mode32Q && (idxInc[1:0] == 2'b11)) begin
      nextIdx = idxInc + (AddrW+1)'(1);
    end
    isLast = nextIdx > {1'b0, lastIdxQ};
  end

  always_ff @(posedge busClk or posedge busRst) begin
    if (busRst) begin
      fsmQ     <= StIdle;
      byteIdxQ <= '0;
      lastIdxQ <= '0;
      mode32Q  <= 1'b0;
      shiftQ   <= '0;
      bitCntQ  <= '0;
      cntQ     <= '0;
    end else begin
      fsmQ     <= fsmD;
      byteIdxQ <= byteIdxD;
      lastIdxQ <= lastIdxD;
      mode32Q  <= mode32D;
      shiftQ   <= shiftD;
      bitCntQ  <= bitCntD;
      cntQ     <= cntD;
    end
  end

  always_comb begin
    fsmD     = fsmQ;
    byteIdxD = byteIdxQ;
    lastIdxD = lastIdxQ;
    mode32D  = mode32Q;
    shiftD   = shiftQ;
    bitCntD  = bitCntQ;
    cntD     = cntQ;
    unique case (fsmQ)
      StIdle: begin
        if (regCtrlRun) begin
          fsmD     = StLoad;
          byteIdxD = '0;
          lastIdxD = lastSel;
          mode32D  = regCtrl32bit;
        end
      end
      StLoad: begin
        shiftD  = pixelData;
        bitCntD = '0;
        cntD    = '0;
        fsmD    = StBit;
      end
      StBit: begin
        // The LOAD cycle doubles as the final low cycle of the byte's last bit.
        if ((bitCntQ == 3'd7) && !isLast && (cntQ == BitLoad)) begin
          fsmD     = StLoad;
          byteIdxD = nextIdx[AddrW-1:0];
        end else if (cntQ == BitLast) begin
          cntD = '0;
          if (bitCntQ == 3'd7) begin
            fsmD = StLatch;
          end else begin
            bitCntD = bitCntQ + 3'd1;
            shiftD  = {shiftQ[6:0], 1'b0};
          end
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      StLatch: begin
        if (cntQ == LatchLast) begin
          fsmD = StIdle;
          cntD = '0;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      default: fsmD = StIdle;
    endcase
  end

  assign state        = (fsmQ != StIdle);
  assign pixelAddr    = byteIdxQ;
  assign neoData      = (fsmQ == StBit) && (cntQ < (shiftQ[7] ? T1hCnt : T0hCnt));
  assign streamSyncOf = (fsmQ == StLatch) && (cntQ == LatchLast);

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Bench for anton_neopixel_stream: captures whole frames and compares them with a
// waveform built directly from the buffer contents and the frame rules.

module tb_anton_neopixel_stream;

  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int BITC = 6;
  localparam int RSTC = 10;
  localparam int BEND = 7;
  localparam int AW   = 3;

  logic          busClk = 1'b0;
  logic          busRst;
  logic [12:0]   regMax;
  logic          regCtrlLimit, regCtrlRun, regCtrl32bit;
  logic [AW-1:0] pixelAddr;
  logic [7:0]    pixelData;
  logic          neoData, streamSyncOf, state;

  logic [7:0] mem [0:BEND];
  assign pixelData = mem[pixelAddr];

  anton_neopixel_stream #(
    .BUFFER_END  (BEND),
    .CYCLES_T0H  (T0H),
    .CYCLES_T1H  (T1H),
    .CYCLES_BIT  (BITC),
    .CYCLES_RESET(RSTC)
  ) dut (
    .busClk      (busClk),
    .busRst      (busRst),
    .regMax      (regMax),
    .regCtrlLimit(regCtrlLimit),
    .regCtrlRun  (regCtrlRun),
    .regCtrl32bit(regCtrl32bit),
    .pixelAddr   (pixelAddr),
    .pixelData   (pixelData),
    .neoData     (neoData),
    .streamSyncOf(streamSyncOf),
    .state       (state)
  );

  always #5 busClk = ~busClk;

  int checks = 0;
  int failures = 0;
  int expNeo[$], expSync[$], expAddr[$];
  int gotNeo[$], gotSync[$], gotAddr[$];

  typedef struct {
    logic limit;
    int   maxv;
    logic b32;
    int   nBytes;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Expected frame from the first LOAD cycle to the last LATCH cycle; addr -1 = don't care.
  task automatic buildModel(input logic limit, input int maxv, input logic b32);
    int last;
    int idxs[$];
    expNeo.delete(); expSync.delete(); expAddr.delete();
    last = limit ? ((maxv > BEND) ? BEND : maxv) : BEND;
    for (int i = 0; i <= last; i++) if (!(b32 && (i % 4 == 3))) idxs.push_back(i);
    expNeo.push_back(0); expSync.push_back(0); expAddr.push_back(0);
    foreach (idxs[k]) begin
      logic [7:0] v;
      v = mem[idxs[k]];
      for (int b = 7; b >= 0; b--) begin
        int h;
        h = v[b] ? T1H : T0H;
        for (int c = 0; c < BITC; c++) begin
          expNeo.push_back((c < h) ? 1 : 0);
          expSync.push_back(0);
          expAddr.push_back((b == 0 && c == BITC - 1) ? -1 : idxs[k]);
        end
      end
    end
    for (int c = 0; c < RSTC; c++) begin
      expNeo.push_back(0);
      expSync.push_back((c == RSTC - 1) ? 1 : 0);
      expAddr.push_back(-1);
    end
  endtask

  // Records one frame while state is high; returns at the first negedge with state low.
  task automatic capture(input int dropAt);
    int waitN;
    waitN = 0;
    gotNeo.delete(); gotSync.delete(); gotAddr.delete();
    while (state !== 1'b1 && waitN < 4) begin
      @(negedge busClk);
      waitN++;
    end
    if (state !== 1'b1) begin
      check("frame_start", {31'd0, state}, 1);
      return;
    end
    while (state === 1'b1 && gotNeo.size() < 1000) begin
      gotNeo.push_back(int'(neoData));
      gotSync.push_back(int'(streamSyncOf));
      gotAddr.push_back(int'(pixelAddr));
      if (gotNeo.size() == dropAt) begin
        regCtrlRun   = 1'b0;
        regMax       = 13'($urandom);
        regCtrlLimit = 1'($urandom);
        regCtrl32bit = 1'($urandom);
      end
      @(negedge busClk);
    end
  endtask

  task automatic compareFrame(input string tag, input int nBytes);
    int n, neoBad, syncBad, addrBad;
    neoBad = 0; syncBad = 0; addrBad = 0;
    check({tag, "_len"}, gotNeo.size(), 1 + 8 * BITC * nBytes + RSTC);
    n = (gotNeo.size() < expNeo.size()) ? gotNeo.size() : expNeo.size();
    for (int i = 0; i < n; i++) begin
      if (gotNeo[i] != expNeo[i]) neoBad++;
      if (gotSync[i] != expSync[i]) syncBad++;
      if (expAddr[i] >= 0 && gotAddr[i] != expAddr[i]) addrBad++;
    end
    check({tag, "_neo_bad_cycles"}, neoBad, 0);
    check({tag, "_sync_bad_cycles"}, syncBad, 0);
    check({tag, "_addr_bad_cycles"}, addrBad, 0);
  endtask

  task automatic fillMem();
    for (int i = 0; i <= BEND; i++) mem[i] = 8'($urandom);
  endtask

  task automatic startFrame(input logic limit, input int maxv, input logic b32);
    @(negedge busClk);
    regCtrlLimit = limit;
    regMax       = 13'(maxv);
    regCtrl32bit = b32;
    regCtrlRun   = 1'b1;
    @(negedge busClk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int cnt, waitN, syncSeen;
    vecs[0] = '{1'b1, 0,   1'b0, 1};
    vecs[1] = '{1'b0, 0,   1'b1, 6};
    vecs[2] = '{1'b1, 100, 1'b0, 8};
    vecs[3] = '{1'b1, 3,   1'b1, 3};
    vecs[4] = '{1'b0, 5,   1'b0, 8};
    vecs[5] = '{1'b1, 5,   1'b1, 5};
    vecs[6] = '{1'b1, 7,   1'b1, 6};

    busRst = 1'b1;
    regMax = '0; regCtrlLimit = 0; regCtrlRun = 0; regCtrl32bit = 0;
    fillMem();
    #1;
    check("rst_state", {31'd0, state}, 0);
    check("rst_neo", {31'd0, neoData}, 0);
    check("rst_sync", {31'd0, streamSyncOf}, 0);
    check("rst_addr", {29'd0, pixelAddr}, 0);
    repeat (3) @(negedge busClk);
    busRst = 1'b0;
    @(negedge busClk);
    check("idle_no_run", {31'd0, state}, 0);

    for (int v = 0; v < 7; v++) begin
      fillMem();
      if (v == 0) mem[0] = 8'hA5;
      buildModel(vecs[v].limit, vecs[v].maxv, vecs[v].b32);
      startFrame(vecs[v].limit, vecs[v].maxv, vecs[v].b32);
      capture(1);
      compareFrame($sformatf("vec%0d", v), vecs[v].nBytes);
    end

    // Loop mode: exactly one IDLE cycle between frames, then drop run mid-frame.
    fillMem();
    buildModel(1'b1, 1, 1'b0);
    startFrame(1'b1, 1, 1'b0);
    capture(0);
    compareFrame("loop1", 2);
    check("loop_idle_state", {31'd0, state}, 0);
    @(negedge busClk);
    check("loop_restart", {31'd0, state}, 1);
    capture(40);
    compareFrame("loop2", 2);
    cnt = 0;
    repeat (20) begin
      @(negedge busClk);
      if (state === 1'b1) cnt++;
    end
    check("loop_stopped", cnt, 0);

    // Reset during byte 2.
    fillMem();
    startFrame(1'b0, 0, 1'b0);
    regCtrlRun = 1'b0;
    waitN = 0;
    while (pixelAddr !== 3'd2 && waitN < 300) begin
      @(negedge busClk);
      waitN++;
    end
    check("rst_reach_byte2", {29'd0, pixelAddr}, 2);
    repeat (9) @(negedge busClk);
    #2 busRst = 1'b1;
    #1;
    check("midrst_neo", {31'd0, neoData}, 0);
    check("midrst_state", {31'd0, state}, 0);
    check("midrst_addr", {29'd0, pixelAddr}, 0);
    syncSeen = 0;
    repeat (4) begin
      @(negedge busClk);
      if (streamSyncOf !== 1'b0) syncSeen++;
    end
    check("midrst_no_sync", syncSeen, 0);
    fillMem();
    buildModel(1'b1, 1, 1'b0);
    regCtrlLimit = 1'b1; regMax = 13'd1; regCtrl32bit = 1'b0; regCtrlRun = 1'b1;
    busRst = 1'b0;
    @(negedge busClk);
    check("rst_first_edge", {31'd0, state}, 1);
    check("rst_fresh_addr", {29'd0, pixelAddr}, 0);
    capture(1);
    compareFrame("afterrst", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_stream.md
ANTON_NEOPIXEL_STREAM -- requirements
Module: anton_neopixel_stream

Interface
REQ-001 SHALL have parameter BUFFER_END, default `BUFFER_END_DEFAULT, index of the last byte in the pixel buffer.
REQ-002 SHALL have parameter CYCLES_T0H, default 20, number of high cycles for a 0 bit.
REQ-003 SHALL have parameter CYCLES_T1H, default 40, number of high cycles for a 1 bit.
REQ-004 SHALL have parameter CYCLES_BIT, default 63, total cycles per bit; it SHALL be greater than CYCLES_T1H, and CYCLES_T1H SHALL be greater than CYCLES_T0H.
REQ-005 SHALL have parameter CYCLES_RESET, default 2500, number of low latch cycles after a frame.
REQ-006 SHALL have port busClk, input, 1 bit: the single clock; every flop SHALL sit on its rising edge.
REQ-007 SHALL have port busRst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port regMax, input, 13 bits: index of the last byte to send when limit mode is on.
REQ-009 SHALL have ports regCtrlLimit, regCtrlRun and regCtrl32bit, each input, 1 bit: control flags from the register block.
REQ-010 SHALL have port pixelAddr, output, CLOG2(BUFFER_END+1) bits: read address into the pixel buffer.
REQ-011 SHALL have port pixelData, input, 8 bits: buffer byte at pixelAddr, valid combinationally in the same cycle.
REQ-012 SHALL have port neoData, output, 1 bit: serial line to the LED chain.
REQ-013 SHALL have port streamSyncOf, output, 1 bit: one-cycle end-of-frame pulse.
REQ-014 SHALL have port state, output, 1 bit: 1 while a frame or its latch period is in progress.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, LOAD, BIT, LATCH.
REQ-016 In IDLE, SHALL sample regCtrlRun each cycle; when it is 1, SHALL clear the byte index and go to LOAD on the next edge.
REQ-017 In LOAD (one cycle), SHALL capture pixelData into an 8-bit shift register, clear the bit and cycle counters, and go to BIT.
REQ-018 In BIT, SHALL send bits MSB first, one bit every CYCLES_BIT cycles.
REQ-019 Within each bit, neoData SHALL be 1 for the first CYCLES_T1H (bit=1) or CYCLES_T0H (bit=0) cycles and 0 for the rest.
REQ-020 After the 8th bit of a byte, SHALL go to LOAD for the next sent byte, or to LATCH if the byte was the last one.
REQ-021 The LOAD cycle SHALL NOT stretch bit timing; the next byte's first high cycle SHALL directly follow the previous bit's last cycle.
REQ-022 Last byte index SHALL be min(regMax, BUFFER_END) when regCtrlLimit=1, else BUFFER_END; regMax and regCtrlLimit SHALL be sampled only on leaving IDLE.
REQ-023 When regCtrl32bit=1, bytes with index[1:0]==3 SHALL be skipped; if the last index is a skipped byte, the frame SHALL end at the preceding byte.
REQ-024 regCtrl32bit SHALL be sampled only on leaving IDLE.
REQ-025 In LATCH, neoData SHALL be 0 for CYCLES_RESET cycles.
REQ-026 streamSyncOf SHALL be high during the final LATCH cycle only; the FSM SHALL then return to IDLE.
REQ-027 After returning to IDLE, a still-high regCtrlRun (loop mode) SHALL start the next frame with exactly one IDLE cycle.
REQ-028 Deasserting regCtrlRun mid-frame SHALL NOT abort the frame; it SHALL complete, including LATCH.
REQ-029 state SHALL be 0 in IDLE and 1 in all other states.
REQ-030 neoData SHALL be 0 in IDLE, LOAD-from-IDLE and LATCH.
REQ-031 pixelAddr SHALL equal the current byte index.
REQ-032 Cycle counter width SHALL be CLOG2(max(CYCLES_BIT, CYCLES_RESET)) bits, with no wrap within a state.

Reset
REQ-033 While busRst=1, the FSM SHALL be in IDLE, and neoData, streamSyncOf, state, pixelAddr and all counters SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL drop neoData to 0 immediately (asynchronous) and SHALL NOT emit streamSyncOf.
REQ-035 After busRst deasserts, the first IDLE sample of regCtrlRun SHALL happen on the first rising edge.

Verification (bench parameters T0H=2, T1H=4, BIT=6, RESET=10, BUFFER_END=7)
REQ-036 Buffer 0xA5 at byte 0, limit=1, regMax=0, run pulsed -> neoData high-time pattern 4,2,4,2,2,4,2,4 over 48 cycles, then 10 low cycles, with streamSyncOf high in the 10th.
REQ-037 limit=0, 32bit=1 -> bytes 0,1,2,4,5,6 are sent, 6 bytes total (288 bit cycles), and pixelAddr never equals 3 or 7 during BIT.
REQ-038 limit=1, regMax=100 -> clamped to 7, 8 bytes sent; limit=1, regMax=3, 32bit=1 -> 3 bytes sent.
REQ-039 run held high -> frames repeat with exactly one IDLE cycle between streamSyncOf and the next LOAD; run dropped mid-frame -> the current frame completes and the next does not start.
REQ-040 busRst asserted in BIT of byte 2 -> neoData=0 and state=0 the same cycle, no streamSyncOf; after release with run=1 -> a fresh frame starts at byte 0.
